// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory stage sitting between the EX/MEM and MEM/WB pipeline registers.
// Executes data-memory loads and stores plus the stack operations PUSH, POP
// and RET, and owns the stack pointer. Memory accesses use a req/ack
// handshake. Upstream is frozen while an access is outstanding, and an access
// that never gets acknowledged is aborted after TIMEOUT busy cycles.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid            EX/MEM holds a valid instruction
//   mem_read_in         load from alu_result_in
//   mem_write_in        store store_data_in to alu_result_in
//   push_in             write store_data_in at SP, then SP-1
//   pop_in, is_ret_in   SP+1, then read from the new SP (RET also flagged)
//   alu_result_in       ALU result / effective address
//   store_data_in       store / push data
//   stall_o             freeze upstream and hold EX/MEM
//   dmem_*              data-memory request channel (req, we, addr, wdata,
//                       ack, rdata)
//   out_valid           one-cycle completion pulse towards MEM/WB
//   alu_result_out      registered ALU result of the completed instruction
//   mem_data_out        loaded/popped data, 0 for non-load operations
//   sp_out              current stack pointer
//   sp_update_out       completed instruction changed SP
//   is_ret_out          completed instruction was a RET
//   mem_err             sticky flag, a request timed out (cleared by rst)
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] SP_RESET = 8'hFF,
    parameter logic [3:0]    TIMEOUT  = 4'd15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic          push_in,
    input  logic          pop_in,
    input  logic          is_ret_in,
    input  logic [DW-1:0] alu_result_in,
    input  logic [DW-1:0] store_data_in,
    output logic          stall_o,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          out_valid,
    output logic [DW-1:0] alu_result_out,
    output logic [DW-1:0] mem_data_out,
    output logic [DW-1:0] sp_out,
    output logic          sp_update_out,
    output logic          is_ret_out,
    output logic          mem_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, next_state;
    logic [3:0]    cnt;
    logic [DW-1:0] sp;

    // Operation latched when the request is launched, used at completion.
    logic          op_push, op_pop, op_read, op_ret;
    logic [DW-1:0] op_alu;

    // Decoded view of the incoming instruction, resolved by priority
    // push > pop/ret > write > read.
    logic          mem_op, dec_push, dec_pop, dec_write, dec_read;
    logic [DW-1:0] req_addr, req_wdata;
    logic          done, timed_out;

    assign sp_out = sp;

    // Operation decode and request address/data selection.
    always_comb begin
        mem_op    = push_in | pop_in | is_ret_in | mem_write_in | mem_read_in;
        dec_push  = push_in;
        dec_pop   = !push_in && (pop_in || is_ret_in);
        dec_write = !push_in && !pop_in && !is_ret_in && mem_write_in;
        dec_read  = !push_in && !pop_in && !is_ret_in && !mem_write_in && mem_read_in;
        req_addr  = alu_result_in;
        req_wdata = '0;
        if (dec_push) begin
            req_addr  = sp;
            req_wdata = store_data_in;
        end else if (dec_pop) begin
            req_addr  = sp + 1'b1;
        end else if (dec_write) begin
            req_wdata = store_data_in;
        end
    end

    // A busy access finishes on ack, or is forced to finish once the wait
    // counter reaches TIMEOUT; an ack in that last cycle still counts.
    always_comb begin
        done      = (state == BUSY) && (dmem_ack || cnt == TIMEOUT);
        timed_out = (state == BUSY) && !dmem_ack && cnt == TIMEOUT;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid && mem_op) next_state = BUSY;
            BUSY: if (done)               next_state = IDLE;
            default:                      next_state = IDLE;
        endcase
    end

    // Stall is combinational so upstream freezes in the same cycle a memory
    // operation is seen, and stays up through the completing busy cycle.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = in_valid && mem_op;
            BUSY:    stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    // Datapath: request launch, wait counting, completion and SP update.
    // Result outputs hold their values between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            sp             <= SP_RESET;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            out_valid      <= 1'b0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
            sp_update_out  <= 1'b0;
            is_ret_out     <= 1'b0;
            mem_err        <= 1'b0;
            op_push        <= 1'b0;
            op_pop         <= 1'b0;
            op_read        <= 1'b0;
            op_ret         <= 1'b0;
            op_alu         <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && !mem_op) begin
                    out_valid      <= 1'b1;
                    alu_result_out <= alu_result_in;
                    is_ret_out     <= is_ret_in;
                    mem_data_out   <= '0;
                    sp_update_out  <= 1'b0;
                end else if (in_valid) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= dec_push | dec_write;
                    dmem_addr  <= req_addr;
                    dmem_wdata <= req_wdata;
                    cnt        <= '0;
                    op_push    <= dec_push;
                    op_pop     <= dec_pop;
                    op_read    <= dec_pop | dec_read;
                    op_ret     <= is_ret_in;
                    op_alu     <= alu_result_in;
                end
            end else if (done) begin
                dmem_req       <= 1'b0;
                out_valid      <= 1'b1;
                alu_result_out <= op_alu;
                is_ret_out     <= op_ret;
                mem_data_out   <= (op_read && !timed_out) ? dmem_rdata : '0;
                sp_update_out  <= op_push | op_pop;
                if (op_push)   sp <= sp - 1'b1;
                else if (op_pop) sp <= sp + 1'b1;
                if (timed_out) mem_err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage. The bench plays the data memory
// (a 256-entry array answering after a chosen number of busy cycles, or never)
// and keeps its own model of the stack pointer, the memory contents and the
// sticky error flag. Directed cases cover the documented scenarios; a random
// loop then mixes operation types, overlapping op bits and ack delays.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, mem_read_in, mem_write_in, push_in, pop_in, is_ret_in;
    logic [7:0] alu_result_in, store_data_in;
    logic       stall_o, dmem_req, dmem_we, dmem_ack;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       out_valid, sp_update_out, is_ret_out, mem_err;
    logic [7:0] alu_result_out, mem_data_out, sp_out;

    int errors = 0;
    int checks = 0;

    // Reference state: stack pointer, memory image and sticky error.
    logic [7:0] spModel;
    logic       errModel;
    logic [7:0] memArr [256];

    mem_access_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .push_in(push_in), .pop_in(pop_in), .is_ret_in(is_ret_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .alu_result_out(alu_result_out),
        .mem_data_out(mem_data_out), .sp_out(sp_out),
        .sp_update_out(sp_update_out), .is_ret_out(is_ret_out),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Run one instruction through the stage, starting and ending at a
    // negative clock edge. ackDelay = number of busy cycles up to and
    // including the ack cycle; 0 means memory never answers (timeout).
    task automatic applyStimulus(input logic push, input logic pop, input logic ret,
                                 input logic wr, input logic rd,
                                 input logic [7:0] alu, input logic [7:0] sdata,
                                 input int ackDelay);
        logic       memOp, isPush, isPop, isWrite, isRead, timedOut, expWe;
        logic [7:0] expAddr, expData;
        int         doneIdx, stallCount;
        memOp   = push | pop | ret | wr | rd;
        isPush  = push;
        isPop   = !push && (pop || ret);
        isWrite = !push && !pop && !ret && wr;
        isRead  = !push && !pop && !ret && !wr && rd;
        timedOut = (ackDelay == 0) || (ackDelay > 16);
        doneIdx  = timedOut ? 15 : ackDelay - 1;
        expWe    = isPush || isWrite;
        expAddr  = isPush ? spModel : (isPop ? spModel + 8'd1 : alu);

        in_valid = 1'b1; push_in = push; pop_in = pop; is_ret_in = ret;
        mem_write_in = wr; mem_read_in = rd;
        alu_result_in = alu; store_data_in = sdata;
        #1;
        checkOutput("stall_first", stall_o, memOp);

        if (!memOp) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput("alu_valid", out_valid, 1'b1);
            checkOutput("alu_result", alu_result_out, alu);
            checkOutput("alu_memdata", mem_data_out, 8'h00);
            checkOutput("alu_spupd", sp_update_out, 1'b0);
            checkOutput("alu_sp", sp_out, spModel);
        end else begin
            stallCount = 1;
            @(negedge clk);
            checkOutput("req", dmem_req, 1'b1);
            checkOutput("req_we", dmem_we, expWe);
            checkOutput("req_addr", dmem_addr, expAddr);
            if (expWe) checkOutput("req_wdata", dmem_wdata, sdata);
            for (int k = 0; k < 16; k++) begin
                dmem_ack   = (k == doneIdx) && !timedOut;
                dmem_rdata = memArr[dmem_addr];
                #1;
                if (stall_o) stallCount++;
                if (k > 0) begin
                    checkOutput("busy_hold_addr", dmem_addr, expAddr);
                    checkOutput("busy_no_valid", out_valid, 1'b0);
                end
                @(negedge clk);
                if (k == doneIdx) break;
            end
            dmem_ack = 1'b0;
            in_valid = 1'b0;

            // Reference outcome of the completed access.
            expData = (!timedOut && (isPop || isRead)) ? memArr[expAddr] : 8'h00;
            if (!timedOut && expWe) memArr[expAddr] = sdata;
            if (isPush) spModel = spModel - 8'd1;
            if (isPop)  spModel = spModel + 8'd1;
            if (timedOut) errModel = 1'b1;

            checkOutput("done_valid", out_valid, 1'b1);
            checkOutput("done_req_drop", dmem_req, 1'b0);
            checkOutput("done_alu", alu_result_out, alu);
            checkOutput("done_memdata", mem_data_out, expData);
            checkOutput("done_sp", sp_out, spModel);
            checkOutput("done_spupd", sp_update_out, isPush || isPop);
            checkOutput("done_isret", is_ret_out, ret);
            checkOutput("done_err", mem_err, errModel);
            checkOutput("stall_cycles", stallCount, doneIdx + 2);
            #1;
            checkOutput("stall_release", stall_o, 1'b0);
        end

        // Idle gap with a stray ack, which must be ignored.
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        checkOutput("gap_valid", out_valid, 1'b0);
        checkOutput("gap_req", dmem_req, 1'b0);
        checkOutput("gap_sp", sp_out, spModel);
    endtask

    initial begin
        int         level, delay;
        logic [4:0] bits;

        for (int i = 0; i < 256; i++) memArr[i] = 8'($urandom);
        rst = 1'b1; in_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        push_in = 1'b0; pop_in = 1'b0; is_ret_in = 1'b0;
        alu_result_in = 8'h00; store_data_in = 8'h00;
        dmem_ack = 1'b0; dmem_rdata = 8'h00;
        spModel = 8'hFF; errModel = 1'b0;

        @(negedge clk); @(negedge clk);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_sp", sp_out, 8'hFF);
        checkOutput("rst_req", dmem_req, 1'b0);
        checkOutput("rst_err", mem_err, 1'b0);
        checkOutput("rst_alu", alu_result_out, 8'h00);
        checkOutput("rst_stall", stall_o, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // push, pop, ret, write, read
        applyStimulus(0, 0, 0, 0, 0, 8'h3C, 8'h00, 1);   // ADD
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'hA5, 2);   // PUSH 0xA5
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);   // POP -> 0xA5
        applyStimulus(0, 0, 0, 0, 1, 8'h10, 8'h00, 0);   // LOAD, timeout
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 1);   // POP at 0xFF -> addr 0x00
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h5A, 3);   // PUSH at 0x00 -> wrap
        applyStimulus(0, 0, 1, 0, 0, 8'h77, 8'h00, 3);   // RET
        applyStimulus(1, 1, 1, 1, 1, 8'h42, 8'hC3, 16);  // priority, ack on last cycle

        // Reset in the middle of a busy access.
        in_valid = 1'b1; push_in = 1'b1; pop_in = 1'b0; is_ret_in = 1'b0;
        mem_write_in = 1'b0; mem_read_in = 1'b0; store_data_in = 8'h99;
        @(negedge clk); @(negedge clk);
        in_valid = 1'b0; push_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_req", dmem_req, 1'b0);
        checkOutput("midrst_sp", sp_out, 8'hFF);
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_err", mem_err, 1'b0);
        rst = 1'b0;
        spModel = 8'hFF; errModel = 1'b0;
        @(negedge clk);

        // Random mix: lower-priority bits are randomised under the chosen op.
        for (int n = 0; n < 60; n++) begin
            level = $urandom_range(0, 5);
            bits  = 5'($urandom);
            case (level)
                0: bits = 5'b00000;
                1: bits[4] = 1'b1;
                2: begin bits[4] = 1'b0; bits[3] = 1'b1; end
                3: begin bits[4] = 1'b0; bits[2] = 1'b1; end
                4: begin bits[4:2] = 3'b000; bits[1] = 1'b1; end
                default: bits = 5'b00001;
            endcase
            delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            applyStimulus(bits[4], bits[3], bits[2], bits[1], bits[0],
                          8'($urandom), 8'($urandom), delay);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
